// File: rtl/program_counter.sv
// program_counter: fetch-stage PC, advances by STEP each edge or loads a taken branch/jump target.
module program_counter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned STEP     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              pc_branch,
  output logic [ADDR_W-1:0] pc_out
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  // Redirect target is taken verbatim; the increment wraps modulo 2^ADDR_W.
  always_comb pc_d = pc_branch ? pc_next : pc_q + ADDR_W'(STEP);
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= ADDR_W'(RESET_PC);
    else       pc_q <= pc_d;
  assign pc_out = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vectors; stimulus queues expected PC values, a monitor pops and checks them.
module tb_program_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pc_next;
  logic       pc_branch;
  logic [9:0] pc_out;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];
  event       push_ev;

  program_counter dut (
    .clk(clk),
    .reset(reset),
    .pc_next(pc_next),
    .pc_branch(pc_branch),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic expect_pc(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    -> push_ev;
  endtask

  // Inputs change at the falling edge; the expected value is queued just after the rising edge.
  task automatic step(input string tag, input logic r, input logic br, input logic [9:0] nx,
                      input logic [9:0] e);
    @(negedge clk);
    reset = r;
    pc_branch = br;
    pc_next = nx;
    @(posedge clk);
    #1 expect_pc(tag, e);
  endtask

  initial begin
    forever begin
      @(push_ev);
      #1;
      while (exp_q.size() > 0) begin
        logic [9:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (pc_out !== e) begin
          n_err++;
          $display("FAIL %s: pc_out=%0d expected=%0d at %0t", t, pc_out, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pc_branch = 1'b1;
    pc_next = 10'd77;
    #1 expect_pc("reset_t0", 10'd0);
    @(posedge clk);
    #1 expect_pc("reset_held_branch", 10'd0);
    step("release0", 1'b0, 1'b0, 10'd0, 10'd4);
    step("seq8", 1'b0, 1'b0, 10'd0, 10'd8);
    step("seq12", 1'b0, 1'b0, 10'd0, 10'd12);
    step("seq16", 1'b0, 1'b0, 10'd0, 10'd16);
    step("br40", 1'b0, 1'b1, 10'd40, 10'd40);
    for (int i = 1; i <= 4; i++)
      step("seq_after40", 1'b0, 1'b0, 10'd0, 10'(40 + 4 * i));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 expect_pc("async_reset", 10'd0);
    step("reset_over_branch", 1'b1, 1'b1, 10'd300, 10'd0);
    step("release_after_async", 1'b0, 1'b0, 10'd300, 10'd4);
    step("br100", 1'b0, 1'b1, 10'd100, 10'd100);
    for (int i = 1; i <= 4; i++)
      step("seq_after100", 1'b0, 1'b0, 10'(i * 37), 10'(100 + 4 * i));
    for (int i = 0; i < 3; i++)
      step("held200", 1'b0, 1'b1, 10'd200, 10'd200);
    step("seq204", 1'b0, 1'b0, 10'd999, 10'd204);
    step("br1016", 1'b0, 1'b1, 10'd1016, 10'd1016);
    step("seq1020", 1'b0, 1'b0, 10'd0, 10'd1020);
    step("wrap0", 1'b0, 1'b0, 10'd0, 10'd0);
    step("wrap4", 1'b0, 1'b0, 10'd0, 10'd4);
    step("br1022", 1'b0, 1'b1, 10'd1022, 10'd1022);
    step("wrap_unaligned", 1'b0, 1'b0, 10'd0, 10'd2);
    step("br_unaligned", 1'b0, 1'b1, 10'd513, 10'd513);
    step("seq517", 1'b0, 1'b0, 10'd0, 10'd517);
    #5;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
